// File: rtl/pcie_os_pkg.sv
// Shared symbol constants, request encodings and helpers for the PCIe ordered-set generator.
package pcie_os_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] PAD_SYM = 8'hF7;
  localparam logic [7:0] TS1_ID  = 8'h4A;
  localparam logic [7:0] TS2_ID  = 8'h45;
  localparam logic [7:0] IDL_SYM = 8'h00;

  typedef enum logic [2:0] {
    OsTs1  = 3'b000,
    OsTs2  = 3'b001,
    OsIdle = 3'b100
  } os_type_e;

  localparam logic [1:0] LANE_MODE_PAD = 2'b00;
  localparam logic [1:0] LANE_MODE_SEQ = 2'b01;

  typedef struct packed {
    os_type_e    os_type;
    logic [1:0]  lane_mode;
    logic [7:0]  link;
    logic [2:0]  rate;
    logic        loopback;
  } os_req_t;

  // Data-rate identifier: one bit per supported generation from bit 1 up to the highest rate.
  function automatic logic [7:0] rate_byte(input logic [2:0] rate);
    logic [2:0] r;
    r = ((rate == 3'd0) || (rate > 3'd5)) ? 3'd5 : rate;
    rate_byte = 8'h00;
    for (int b = 1; b <= 5; b++) begin
      if (3'(b) <= r) rate_byte[b] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/os_lane_symbol_sel.sv
// Combinational symbol selector: one lane's PIPE word (and K flags) for a given word index.
module os_lane_symbol_sel
  import pcie_os_pkg::*;
#(
  parameter int unsigned PIPEWIDTH = 8,
  parameter logic [7:0]  NFTS      = 8'h20
) (
  input  os_req_t                    req_i,
  input  logic [7:0]                 lane_idx_i,
  input  logic [3:0]                 wc_i,
  output logic [PIPEWIDTH-1:0]       data_o,
  output logic [PIPEWIDTH/8-1:0]     k_o
);

  localparam int unsigned SPC = PIPEWIDTH / 8;

  logic [3:0] sidx;
  logic [7:0] sym;
  logic       sym_k;

  always_comb begin
    data_o = '0;
    k_o    = '0;
    sidx   = '0;
    sym    = '0;
    sym_k  = 1'b0;
    for (int k = 0; k < int'(SPC); k++) begin
      sidx  = 4'(32'(wc_i) * SPC + 32'(k));
      sym_k = 1'b0;
      if (req_i.os_type == OsIdle) begin
        sym = IDL_SYM;
      end else begin
        case (sidx)
          4'd0: begin
            sym   = COM_SYM;
            sym_k = 1'b1;
          end
          4'd1: begin
            sym   = (req_i.link == 8'h00) ? PAD_SYM : req_i.link;
            sym_k = (req_i.link == 8'h00);
          end
          4'd2: begin
            sym   = (req_i.lane_mode == LANE_MODE_PAD) ? PAD_SYM : lane_idx_i;
            sym_k = (req_i.lane_mode == LANE_MODE_PAD);
          end
          4'd3:    sym = NFTS;
          4'd4:    sym = rate_byte(req_i.rate);
          4'd5:    sym = {5'b0, req_i.loopback, 2'b00};
          default: sym = (req_i.os_type == OsTs2) ? TS2_ID : TS1_ID;
        endcase
      end
      data_o[k*8 +: 8] = sym;
      k_o[k]           = sym_k;
    end
  end

endmodule

// File: rtl/ts_os_generator.sv
// TS1/TS2/IDLE ordered-set generator: latches a request and streams one 16-symbol set per lane.
module ts_os_generator
  import pcie_os_pkg::*;
#(
  parameter int unsigned LANESNUMBER = 16,
  parameter int unsigned PIPEWIDTH   = 8,
  parameter logic [7:0]  NFTS        = 8'h20
) (
  input  logic                                 pclk_i,
  input  logic                                 reset_i,
  input  logic                                 os_gen_start_i,
  input  logic [2:0]                           os_type_i,
  input  logic [1:0]                           lane_number_i,
  input  logic [7:0]                           link_number_i,
  input  logic [2:0]                           rate_i,
  input  logic                                 loopback_i,
  input  logic [LANESNUMBER-1:0]               lane_enable_i,
  output logic                                 os_gen_busy_o,
  output logic                                 os_gen_finish_o,
  output logic [LANESNUMBER*PIPEWIDTH-1:0]     tx_data_o,
  output logic [LANESNUMBER*(PIPEWIDTH/8)-1:0] tx_data_k_o,
  output logic                                 tx_data_valid_o
);

  localparam int unsigned SPC   = PIPEWIDTH / 8;
  localparam int unsigned W     = 16 / SPC;
  localparam logic [3:0]  WLast = 4'(W - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e                              st_q;
  logic [3:0]                          wc_q;
  os_req_t                             req_q, req_d;
  logic [LANESNUMBER-1:0]              en_q, en_d;
  logic                                busy_q, finish_q;
  logic [LANESNUMBER*PIPEWIDTH-1:0]    data_q, data_d, lane_data;
  logic [LANESNUMBER*SPC-1:0]          k_q, k_d, lane_k;

  logic       legal, accept, emit;
  logic [3:0] word_idx;

  // wc_q == 0 in SEND marks the edge right after the last word, where chaining is allowed.
  always_comb begin
    legal    = (os_type_i == OsTs1) || (os_type_i == OsTs2) || (os_type_i == OsIdle);
    accept   = (wc_q == 4'd0) && os_gen_start_i && legal;
    emit     = accept || ((st_q == StSend) && (wc_q != 4'd0));
    word_idx = accept ? 4'd0 : wc_q;
    req_d    = req_q;
    en_d     = en_q;
    if (accept) begin
      req_d.os_type   = os_type_e'(os_type_i);
      req_d.lane_mode = lane_number_i;
      req_d.link      = link_number_i;
      req_d.rate      = rate_i;
      req_d.loopback  = loopback_i;
      en_d            = lane_enable_i;
    end
  end

  for (genvar i = 0; i < int'(LANESNUMBER); i++) begin : g_lane
    os_lane_symbol_sel #(
      .PIPEWIDTH (PIPEWIDTH),
      .NFTS      (NFTS)
    ) u_sel (
      .req_i      (req_d),
      .lane_idx_i (8'(i)),
      .wc_i       (word_idx),
      .data_o     (lane_data[i*PIPEWIDTH +: PIPEWIDTH]),
      .k_o        (lane_k[i*SPC +: SPC])
    );

    assign data_d[i*PIPEWIDTH +: PIPEWIDTH] =
        (emit && en_d[i]) ? lane_data[i*PIPEWIDTH +: PIPEWIDTH] : '0;
    assign k_d[i*SPC +: SPC] = (emit && en_d[i]) ? lane_k[i*SPC +: SPC] : '0;
  end

  always_ff @(posedge pclk_i or posedge reset_i) begin
    if (reset_i) begin
      st_q     <= StIdle;
      wc_q     <= '0;
      req_q    <= '0;
      en_q     <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      data_q   <= '0;
      k_q      <= '0;
    end else begin
      st_q     <= emit ? StSend : StIdle;
      wc_q     <= (emit && (word_idx != WLast)) ? word_idx + 4'd1 : 4'd0;
      req_q    <= req_d;
      en_q     <= en_d;
      busy_q   <= emit;
      finish_q <= emit && (word_idx == WLast);
      data_q   <= data_d;
      k_q      <= k_d;
    end
  end

  assign os_gen_busy_o   = busy_q;
  assign os_gen_finish_o = finish_q;
  assign tx_data_valid_o = busy_q;
  assign tx_data_o       = data_q;
  assign tx_data_k_o     = k_q;

endmodule

// File: tb/tb_ts_os_generator.sv
// Directed bench for ts_os_generator at PIPEWIDTH 8 and 32 sharing one stimulus stream.
module tb_ts_os_generator;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   os_type;
  logic [1:0]   lane_num;
  logic [7:0]   link;
  logic [2:0]   rate;
  logic         lb;
  logic [15:0]  lane_en;

  logic         busy8, fin8, valid8;
  logic [127:0] data8;
  logic [15:0]  k8;
  logic         busy32, fin32, valid32;
  logic [511:0] data32;
  logic [63:0]  k32;

  int n_run  = 0;
  int n_fail = 0;

  logic [8:0] exp_sym [16];

  always #5 clk = ~clk;

  ts_os_generator #(.LANESNUMBER(16), .PIPEWIDTH(8), .NFTS(8'h20)) u_dut8 (
    .pclk_i          (clk),
    .reset_i         (rst),
    .os_gen_start_i  (start),
    .os_type_i       (os_type),
    .lane_number_i   (lane_num),
    .link_number_i   (link),
    .rate_i          (rate),
    .loopback_i      (lb),
    .lane_enable_i   (lane_en),
    .os_gen_busy_o   (busy8),
    .os_gen_finish_o (fin8),
    .tx_data_o       (data8),
    .tx_data_k_o     (k8),
    .tx_data_valid_o (valid8)
  );

  ts_os_generator #(.LANESNUMBER(16), .PIPEWIDTH(32), .NFTS(8'h20)) u_dut32 (
    .pclk_i          (clk),
    .reset_i         (rst),
    .os_gen_start_i  (start),
    .os_type_i       (os_type),
    .lane_number_i   (lane_num),
    .link_number_i   (link),
    .rate_i          (rate),
    .loopback_i      (lb),
    .lane_enable_i   (lane_en),
    .os_gen_busy_o   (busy32),
    .os_gen_finish_o (fin32),
    .tx_data_o       (data32),
    .tx_data_k_o     (k32),
    .tx_data_valid_o (valid32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word 0 must already be visible on entry; walks all 16 words of the 8-bit DUT.
  task automatic check_set8(input string tag, input int lane, input logic [15:0] en);
    logic [127:0] dis_d;
    logic [15:0]  dis_k;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      chk($sformatf("%s w%0d data", tag, i), data8[lane*8 +: 8], exp_sym[i][7:0]);
      chk($sformatf("%s w%0d k", tag, i), k8[lane], exp_sym[i][8]);
      chk($sformatf("%s w%0d busy", tag, i), busy8, 1'b1);
      chk($sformatf("%s w%0d valid", tag, i), valid8, 1'b1);
      chk($sformatf("%s w%0d finish", tag, i), fin8, (i == 15));
      dis_d = '0;
      dis_k = '0;
      for (int l = 0; l < 16; l++) begin
        if (!en[l]) begin
          dis_d[l*8 +: 8] = data8[l*8 +: 8];
          dis_k[l]        = k8[l];
        end
      end
      chk($sformatf("%s w%0d off-lane data", tag, i), dis_d, 128'h0);
      chk($sformatf("%s w%0d off-lane k", tag, i), dis_k, 16'h0);
    end
  endtask

  task automatic check_idle8(input string tag);
    chk({tag, " busy"}, busy8, 1'b0);
    chk({tag, " valid"}, valid8, 1'b0);
    chk({tag, " finish"}, fin8, 1'b0);
    chk({tag, " data"}, data8, 128'h0);
    chk({tag, " k"}, k8, 16'h0);
  endtask

  initial begin
    int fin_cnt;
    int drops;
    int nz;

    rst = 1'b1; start = 1'b0; os_type = 3'b000; lane_num = 2'b00; link = 8'h00;
    rate = 3'd1; lb = 1'b0; lane_en = 16'hFFFF;
    #12;
    check_idle8("reset8");
    chk("reset32 busy", busy32, 1'b0);
    chk("reset32 data", data32, 512'h0);
    chk("reset32 k", k32, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // TS1, PAD link and lane, rate 1, loopback set.
    os_type = 3'b000; link = 8'h00; lane_num = 2'b00; rate = 3'd1; lb = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    exp_sym = '{9'h1BC, 9'h1F7, 9'h1F7, 9'h020, 9'h002, 9'h004, 9'h04A, 9'h04A,
                9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A};
    check_set8("t1", 0, 16'hFFFF);
    tick();
    check_idle8("t1 end");

    // TS2 on the 32-bit DUT: four symbols per word, lane 5 carries its index.
    os_type = 3'b001; link = 8'h01; lane_num = 2'b01; rate = 3'd5; lb = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2 w0 lane5", data32[5*32 +: 32], 32'h2005_01BC);
    chk("t2 w0 lane5 k", k32[5*4 +: 4], 4'b0001);
    chk("t2 w0 lane0", data32[31:0], 32'h2000_01BC);
    chk("t2 w0 busy", busy32, 1'b1);
    chk("t2 w0 finish", fin32, 1'b0);
    tick();
    chk("t2 w1 lane5", data32[5*32 +: 32], 32'h4545_003E);
    chk("t2 w1 lane5 k", k32[5*4 +: 4], 4'b0000);
    tick();
    chk("t2 w2 lane5", data32[5*32 +: 32], 32'h4545_4545);
    chk("t2 w2 finish", fin32, 1'b0);
    tick();
    chk("t2 w3 lane5", data32[5*32 +: 32], 32'h4545_4545);
    chk("t2 w3 finish", fin32, 1'b1);
    chk("t2 w3 valid", valid32, 1'b1);
    tick();
    chk("t2 end busy", busy32, 1'b0);
    chk("t2 end finish", fin32, 1'b0);
    chk("t2 end data", data32, 512'h0);
    chk("t2 dut8 still busy", busy8, 1'b1);
    repeat (12) tick();
    chk("t2 dut8 drained", busy8, 1'b0);

    // IDLE sets back to back with start held high.
    os_type = 3'b100; start = 1'b1;
    fin_cnt = 0; drops = 0; nz = 0;
    for (int c = 1; c <= 1024; c++) begin
      tick();
      if (fin8) fin_cnt++;
      if (!valid8) drops++;
      if ((data8 != 128'h0) || (k8 != 16'h0)) nz++;
    end
    chk("t3 finish count", 32'(fin_cnt), 32'd64);
    chk("t3 valid drops", 32'(drops), 32'd0);
    chk("t3 nonzero idle words", 32'(nz), 32'd0);
    chk("t3 last finish", fin8, 1'b1);
    start = 1'b0;
    tick();
    chk("t3 stop busy8", busy8, 1'b0);
    chk("t3 stop busy32", busy32, 1'b0);

    // Illegal type is ignored; latched fields survive mid-set input changes.
    os_type = 3'b111; start = 1'b1;
    tick();
    check_idle8("t4 illegal a");
    chk("t4 illegal busy32", busy32, 1'b0);
    tick();
    check_idle8("t4 illegal b");
    os_type = 3'b000; link = 8'h11; lane_num = 2'b01; rate = 3'd2; lb = 1'b0;
    tick();
    start = 1'b0;
    os_type = 3'b001; link = 8'h22; lane_num = 2'b00; rate = 3'd3; lb = 1'b1;
    exp_sym = '{9'h1BC, 9'h011, 9'h000, 9'h020, 9'h006, 9'h000, 9'h04A, 9'h04A,
                9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A};
    check_set8("t4", 0, 16'hFFFF);
    tick();
    check_idle8("t4 end");

    // Asynchronous reset in the middle of a set.
    os_type = 3'b000; link = 8'h00; lane_num = 2'b00; rate = 3'd1; lb = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("t5 pre-reset data", data8[7:0], 8'h4A);
    chk("t5 pre-reset busy", busy8, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_idle8("t5 async");
    tick();
    check_idle8("t5 held");
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5 restart data", data8[7:0], 8'hBC);
    chk("t5 restart k", k8[0], 1'b1);
    chk("t5 restart busy", busy8, 1'b1);
    chk("t5 restart finish", fin8, 1'b0);
    repeat (16) tick();
    chk("t5 drained", busy8, 1'b0);

    // Only lanes 0..3 enabled; rate 0 clamps to 5.
    lane_en = 16'h000F; os_type = 3'b000; link = 8'h33; lane_num = 2'b01; rate = 3'd0;
    lb = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    exp_sym = '{9'h1BC, 9'h033, 9'h003, 9'h020, 9'h03E, 9'h000, 9'h04A, 9'h04A,
                9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A};
    check_set8("t6", 3, 16'h000F);
    tick();
    check_idle8("t6 end");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
